fifo_pop_router: RTL and testbench

- Downstream consumer of the main queue FIFO (4-bit words, read/write handshake, registered buff_out, almost_full/almost_empty thresholds).
- Pops words whenever the FIFO is non-empty and both destination queues have room.
- Steers each word to one of two destination FIFOs according to its MSB (destination bit).
- Contains the stage's RESET/INIT/IDLE/ACTIVE control FSM, so higher levels can see when the path is drained.

---
 rtl/fifo_pop_router.sv | 130 +++++++++++++
 tb/tb_fifo_pop_router.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_router.sv
// Pops words from the main queue FIFO and steers each to one of two destination
// FIFOs by its destination bit. Optional per-destination counters: ROUTER_COUNT_EN.

module fifo_pop_router_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       hit,
  output logic       write,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset) write <= 1'b0;
    else       write <= hit;
  end

`ifdef ROUTER_COUNT_EN
  // Counts a strobe the edge after it is seen; sticks at 8'hFF.
  always_ff @(posedge clk) begin
    if (reset || clr)               count <= '0;
    else if (write && count != 8'hFF) count <= count + 8'd1;
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign count      = '0;
`endif

endmodule

module fifo_pop_router #(
  parameter int DATA_W   = 4,
  parameter int DEST_BIT = DATA_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  input  logic              out0_almost_full,
  input  logic              out1_almost_full,
  output logic              out0_write,
  output logic              out1_write,
  output logic [DATA_W-1:0] out_data,
  output logic              idle,
  output logic [1:0]        state,
  output logic [7:0]        count0,
  output logic [7:0]        count1
);

  localparam int NUM_DEST = 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t state_q, state_nxt;
  logic   rd_d;
  logic   init_entry;

  logic [NUM_DEST-1:0]      dest_hit;
  logic [NUM_DEST-1:0]      dest_wr;
  logic [NUM_DEST-1:0][7:0] dest_cnt;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_nxt;
  end

  // init has priority over every other transition out of IDLE/ACTIVE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RESET:  state_nxt = ST_INIT;
      ST_INIT:   if (!init) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (init)             state_nxt = ST_INIT;
        else if (!fifo_empty) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                     state_nxt = ST_INIT;
        else if (fifo_empty && !rd_d) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_RESET;
    endcase
  end

  // Head destination is unknown until the word is read, so both queues must have room.
  assign fifo_read = (state_q == ST_ACTIVE) & ~fifo_empty & ~out0_almost_full &
                     ~out1_almost_full & ~init;

  // rd_d marks a word arriving on fifo_data; once set it is always written out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d     <= 1'b0;
      out_data <= '0;
    end else begin
      rd_d <= fifo_read;
      if (rd_d) out_data <= fifo_data;
    end
  end

  assign init_entry = (state_nxt == ST_INIT) & (state_q != ST_INIT);

  for (genvar l = 0; l < NUM_DEST; l++) begin : g_dest
    assign dest_hit[l] = rd_d & ((l == 1) ? fifo_data[DEST_BIT] : ~fifo_data[DEST_BIT]);

    fifo_pop_router_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (init_entry),
      .hit   (dest_hit[l]),
      .write (dest_wr[l]),
      .count (dest_cnt[l])
    );
  end

  assign out0_write = dest_wr[0];
  assign out1_write = dest_wr[1];
  assign count0     = dest_cnt[0];
  assign count1     = dest_cnt[1];
  assign state      = state_q;
  assign idle       = (state_q == ST_IDLE) & ~rd_d & ~dest_wr[0] & ~dest_wr[1];

endmodule

// File: tb/tb_fifo_pop_router.sv
// Bench for fifo_pop_router: source FIFO model, routing scoreboard, pop-rule table.
module tb_fifo_pop_router;
  localparam int DATA_W = 4;
  localparam int DEST   = DATA_W - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, init, fifo_empty, fifo_read;
  logic out0_almost_full, out1_almost_full, out0_write, out1_write, idle;
  logic [DATA_W-1:0] fifo_data, out_data;
  logic [1:0] state;
  logic [7:0] count0, count1;

  fifo_pop_router #(.DATA_W(DATA_W), .DEST_BIT(DEST)) dut (
    .clk(clk), .reset(reset), .init(init), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read),
    .out0_almost_full(out0_almost_full), .out1_almost_full(out1_almost_full),
    .out0_write(out0_write), .out1_write(out1_write), .out_data(out_data),
    .idle(idle), .state(state), .count0(count0), .count1(count1)
  );

  int n_tests = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, edge_n = 0;
  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int pop_edges[$];

  typedef struct packed {
    logic emp, af0, af1, ini, exp_rd;
  } pop_vec_t;
  pop_vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: source FIFO pops on an accepted read, buff_out valid the next cycle.
  task automatic cyc();
    logic rd;
    logic [DATA_W-1:0] e;
    int p;
    #1;
    rd = fifo_read;
    chk("read_while_empty", {31'b0, rd & fifo_empty}, 0);
    @(posedge clk);
    #1;
    edge_n++;
    if (rd && src_q.size() != 0) begin
      rd_cnt++;
      fifo_data = src_q.pop_front();
      pop_edges.push_back(edge_n);
    end
    fifo_empty = (src_q.size() == 0);
    chk("both_writes", {31'b0, out0_write & out1_write}, 0);
    if (out0_write | out1_write) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        p = pop_edges.pop_front();
        chk("route_data", out_data, e);
        chk("route_dest", out1_write, e[DEST]);
        chk("write_latency", edge_n - p, 1);
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || state != 2'd2 || !idle) && n < budget) begin
      cyc();
      n++;
    end
    chk(name, {31'b0, exp_q.size() == 0 && state == 2'd2 && idle}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {fifo_empty, out0_af, out1_af, init, expected fifo_read} with FSM held in ACTIVE
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; init = 1'b0; fifo_empty = 1'b0; fifo_data = '0;
    out0_almost_full = 1'b0; out1_almost_full = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", fifo_read, 0);
    chk("rst_w0", out0_write, 0);
    chk("rst_w1", out1_write, 0);
    chk("rst_data", out_data, 0);
    chk("rst_state", state, 0);
    chk("rst_idle", idle, 0);
    reset = 1'b0; fifo_empty = 1'b1;
    @(posedge clk); #1;
    chk("rel_state_init", state, 1);
    @(posedge clk); #1;
    chk("rel_state_idle", state, 2);
    chk("rel_idle", idle, 1);

    // Pop-rule table: park in ACTIVE with a word blocked by out0_almost_full
    out0_almost_full = 1'b1;
    push(4'h6);
    cyc();
    chk("table_active", state, 3);
    chk("table_not_idle", idle, 0);
    for (int i = 0; i < 7; i++) begin
      fifo_empty = vecs[i].emp;
      out0_almost_full = vecs[i].af0;
      out1_almost_full = vecs[i].af1;
      init = vecs[i].ini;
      #1;
      chk($sformatf("pop_rule_%0d", i), fifo_read, vecs[i].exp_rd);
    end
    fifo_empty = 1'b0; out0_almost_full = 1'b0; out1_almost_full = 1'b0; init = 1'b0;
    drain("table_drain", 20);

    // Routing: 3,9,A,1
    rd_cnt = 0; wr_cnt = 0;
    push(4'h3); push(4'h9); push(4'hA); push(4'h1);
    drain("route_drain", 30);
    chk("route_reads", rd_cnt, 4);
    chk("route_writes", wr_cnt, 4);
    chk("route_idle", idle, 1);

    // Backpressure: almost_full rises after C and D are popped; E held
    rd_cnt = 0; wr_cnt = 0;
    push(4'hC); push(4'hD); push(4'hE);
    cyc(); cyc(); cyc();
    out1_almost_full = 1'b1;
    #1;
    chk("bp_read_drop", fifo_read, 0);
    repeat (4) cyc();
    chk("bp_reads_held", rd_cnt, 2);
    chk("bp_inflight_written", wr_cnt, 2);
    chk("bp_state_active", state, 3);
    out1_almost_full = 1'b0;
    drain("bp_drain", 20);
    chk("bp_reads_total", rd_cnt, 3);

    // Init mid-stream: 5 in flight still lands on out0
    rd_cnt = 0; wr_cnt = 0;
    push(4'h5); push(4'h2); push(4'hB);
    cyc(); cyc();
    init = 1'b1;
    #1;
    chk("init_read_drop", fifo_read, 0);
    cyc();
    chk("init_state", state, 1);
    chk("init_inflight_written", wr_cnt, 1);
    repeat (2) cyc();
    chk("init_no_reads", rd_cnt, 1);
    init = 1'b0;
    drain("init_drain", 20);
    chk("init_reads_total", rd_cnt, 3);

    // init wins over fifo_empty falling in IDLE
    rd_cnt = 0;
    init = 1'b1;
    push(4'h4);
    #1;
    chk("init_prio_read", fifo_read, 0);
    cyc();
    chk("init_prio_state", state, 1);
    chk("init_prio_reads", rd_cnt, 0);
    init = 1'b0;
    drain("init_prio_drain", 20);

    // Empty boundary: single word 7
    rd_cnt = 0; wr_cnt = 0;
    push(4'h7);
    drain("single_drain", 20);
    chk("single_reads", rd_cnt, 1);
    chk("single_writes", wr_cnt, 1);

    // Reset with a word in flight discards it
    wr_cnt = 0;
    push(4'hF);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    void'(exp_q.pop_front());
    void'(pop_edges.pop_front());
    chk("rst_mid_writes", wr_cnt, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_state", state, 0);
    reset = 1'b0;
    cyc();
    chk("rst_mid_init", state, 1);
    cyc();
    chk("rst_mid_idle", state, 2);
    repeat (2) cyc();
    chk("rst_mid_no_write", wr_cnt, 0);

`ifdef ROUTER_COUNT_EN
    init = 1'b1; cyc(); init = 1'b0; cyc();
    for (int i = 0; i < 300; i++) push(4'h8 | 4'($urandom_range(0, 7)));
    drain("cnt_drain", 1000);
    repeat (2) cyc();
    chk("cnt1_sat", count1, 8'hFF);
    chk("cnt0_zero", count0, 0);
    init = 1'b1;
    cyc();
    chk("cnt1_clr", count1, 0);
    chk("cnt0_clr", count0, 0);
    init = 1'b0;
    drain("cnt_final_drain", 20);
`else
    chk("cnt0_tied", count0, 0);
    chk("cnt1_tied", count1, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
